// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: func codes, opcode/funct7 constants
// and the issue-entry record passed from decode through skid and issue registers.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;
  localparam int unsigned ALU_FUNC_W = 4;

  localparam logic [ALU_FUNC_W-1:0] FUNC_ZERO = 4'd0;
  localparam logic [ALU_FUNC_W-1:0] FUNC_ADD  = 4'd1;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SUB  = 4'd2;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SLL  = 4'd3;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SLT  = 4'd4;
  localparam logic [ALU_FUNC_W-1:0] FUNC_XOR  = 4'd5;
  localparam logic [ALU_FUNC_W-1:0] FUNC_OR   = 4'd6;
  localparam logic [ALU_FUNC_W-1:0] FUNC_AND  = 4'd7;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SRL  = 4'd8;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SRA  = 4'd9;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SLTU = 4'd10;

  localparam logic [6:0] OPC_OP    = 7'h33;
  localparam logic [6:0] OPC_OPIMM = 7'h13;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;

  typedef struct packed {
    logic [ALU_FUNC_W-1:0] func;
    logic [ALU_DATA_W-1:0] op1;
    logic [ALU_DATA_W-1:0] op2;
    logic [4:0]            rd;
    logic                  vld;
    logic                  ill;
  } issue_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I OP/OP-IMM decode into an ALU issue entry.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0]           instr,
  input  logic [ALU_DATA_W-1:0] rs1_data,
  input  logic [ALU_DATA_W-1:0] rs2_data,
  output issue_t                entry
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_sext;
  logic [31:0] shamt_zext;

  assign opcode     = instr[6:0];
  assign f3         = instr[14:12];
  assign f7         = instr[31:25];
  assign imm_sext   = {{20{instr[31]}}, instr[31:20]};
  assign shamt_zext = {27'd0, instr[24:20]};

  always_comb begin
    logic                  legal;
    logic [ALU_FUNC_W-1:0] func;
    logic [ALU_DATA_W-1:0] op2;
    legal = 1'b0;
    func  = FUNC_ZERO;
    op2   = '0;
    if (opcode == OPC_OP) begin
      op2   = rs2_data;
      legal = 1'b1;
      case ({f7, f3})
        {F7_BASE, 3'b000}: func = FUNC_ADD;
        {F7_ALT,  3'b000}: func = FUNC_SUB;
        {F7_BASE, 3'b001}: func = FUNC_SLL;
        {F7_BASE, 3'b010}: func = FUNC_SLT;
        {F7_BASE, 3'b011}: func = FUNC_SLTU;
        {F7_BASE, 3'b100}: func = FUNC_XOR;
        {F7_BASE, 3'b101}: func = FUNC_SRL;
        {F7_ALT,  3'b101}: func = FUNC_SRA;
        {F7_BASE, 3'b110}: func = FUNC_OR;
        {F7_BASE, 3'b111}: func = FUNC_AND;
        default:           legal = 1'b0;
      endcase
    end else if (opcode == OPC_OPIMM) begin
      op2   = imm_sext[ALU_DATA_W-1:0];
      legal = 1'b1;
      case (f3)
        3'b000: func = FUNC_ADD;
        3'b010: func = FUNC_SLT;
        3'b011: func = FUNC_SLTU;
        3'b100: func = FUNC_XOR;
        3'b110: func = FUNC_OR;
        3'b111: func = FUNC_AND;
        3'b001: begin
          op2   = shamt_zext[ALU_DATA_W-1:0];
          func  = FUNC_SLL;
          legal = (f7 == F7_BASE);
        end
        default: begin  // 3'b101: shift right, funct7 picks logical vs arithmetic
          op2   = shamt_zext[ALU_DATA_W-1:0];
          func  = (f7 == F7_ALT) ? FUNC_SRA : FUNC_SRL;
          legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
      endcase
    end

    entry     = '0;
    entry.rd  = instr[11:7];
    entry.vld = legal;
    entry.ill = !legal;
    if (legal) begin
      entry.func = func;
      entry.op1  = rs1_data;
      entry.op2  = op2;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the ALU: decode, 1-entry skid for downstream stalls,
// registered ALU inputs and a 1-stage shadow pipe carrying rd to writeback.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned FUNC_W = ALU_FUNC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              stall,
  output logic [FUNC_W-1:0] alu_func,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              illegal
);

  issue_t dec;
  issue_t issue_q;
  issue_t skid_q;
  logic   skid_full_q;
  logic   wb_valid_q;
  logic   [4:0] wb_rd_q;
  logic   fire;

  alu_decoder u_dec (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .entry    (dec)
  );

  assign in_ready = !skid_full_q;
  assign fire     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q     <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
    end else begin
      if (!stall) begin
        if (skid_full_q) begin
          issue_q     <= skid_q;
          skid_full_q <= 1'b0;
        end else if (fire) begin
          issue_q <= dec;
        end else begin
          issue_q <= '0;
        end
      end else begin
        // ALU inputs hold; the illegal flag is dropped so it only pulses once
        issue_q.ill <= 1'b0;
        if (fire) begin
          skid_q      <= dec;
          skid_full_q <= 1'b1;
        end
      end
      wb_valid_q <= issue_q.vld && !stall && (issue_q.rd != 5'd0);
      wb_rd_q    <= issue_q.rd;
    end
  end

  assign alu_func = issue_q.func;
  assign alu_op1  = issue_q.op1;
  assign alu_op2  = issue_q.op2;
  assign illegal  = issue_q.ill;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;

endmodule
